// File: rtl/ifetch_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encodings,
// reset PC and instruction field positions.
`ifndef IFETCH_SEQ_PKG_SV
`define IFETCH_SEQ_PKG_SV
`define PC_RESET_VAL 32'h0000_3000

package ifetch_seq_pkg;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT,
    IF_EXEC
  } if_state_t;

  // Field positions shared with instruction_def.
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int JIDX_W    = 26;

  function automatic logic [31:0] sext_imm16_x4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`endif

// File: rtl/npc_calc.sv
// Combinational next-PC: jump target, taken branch or sequential pc+4.
module npc_calc
  import ifetch_seq_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [JIDX_W-1:0] jidx,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  output logic [31:0]       next_pc
);

  logic [31:0] p4;

  assign p4 = pc + 32'd4;

  always_comb begin
    // NOTE: default assignment first so no path leaves next_pc unassigned (no latch).
    next_pc = p4;
    if (jump) begin
      next_pc = {p4[31:28], jidx, 2'b00};
    end else if (branch && zero) begin
      next_pc = p4 + sext_imm16_x4(jidx[15:0]);
    end
  end

endmodule

// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: fetches one word over a req/gnt/rvalid port,
// holds it in IR until execute completes, then advances the PC.
module ifetch_seq
  import ifetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = `PC_RESET_VAL,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       OpCode,
  output logic [5:0]       funct,
  output logic             instr_valid,
  output logic [31:0]      pc,
  input  logic             ex_done,
  input  logic             Branch,
  input  logic             zero,
  input  logic             jump,
  output logic [CNT_W-1:0] retired
);

  if_state_t   state;
  logic [31:0] next_pc;

  npc_calc u_npc (
    .pc      (pc),
    .jidx    (instr[JIDX_W-1:0]),
    .branch  (Branch),
    .zero    (zero),
    .jump    (jump),
    .next_pc (next_pc)
  );

  // pc only changes on the way into REQ, so the address is stable while requesting.
  assign imem_addr = pc;
  assign OpCode    = instr[OPCODE_HI:OPCODE_LO];
  assign funct     = instr[FUNCT_HI:FUNCT_LO];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IF_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      retired     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IF_IDLE: begin
          imem_req <= 1'b1;
          state    <= IF_REQ;
        end
        IF_REQ: begin
          if (imem_gnt) begin
            imem_req <= 1'b0;
            if (imem_rvalid) begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= IF_EXEC;
            end else begin
              state <= IF_WAIT;
            end
          end
        end
        IF_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= IF_EXEC;
          end
        end
        IF_EXEC: begin
          if (ex_done) begin
            pc          <= next_pc;
            retired     <= retired + CNT_W'(1);
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= IF_REQ;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: table of fetch/execute rows plus
// hand-written stall, spurious-rvalid, mid-fetch reset and PC-wrap sequences.
module tb_ifetch_seq;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic        ex_done;
  logic        Branch;
  logic        zero;
  logic        jump;
  logic [31:0] retired;

  logic        w_rst_n;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_gnt;
  logic        w_imem_rvalid;
  logic [31:0] w_imem_rdata;
  logic [31:0] w_instr;
  logic [5:0]  w_OpCode;
  logic [5:0]  w_funct;
  logic        w_instr_valid;
  logic [31:0] w_pc;
  logic        w_ex_done;
  logic [31:0] w_retired;

  ifetch_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .OpCode      (OpCode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .ex_done     (ex_done),
    .Branch      (Branch),
    .zero        (zero),
    .jump        (jump),
    .retired     (retired)
  );

  ifetch_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_gnt    (w_imem_gnt),
    .imem_rvalid (w_imem_rvalid),
    .imem_rdata  (w_imem_rdata),
    .instr       (w_instr),
    .OpCode      (w_OpCode),
    .funct       (w_funct),
    .instr_valid (w_instr_valid),
    .pc          (w_pc),
    .ex_done     (w_ex_done),
    .Branch      (1'b0),
    .zero        (1'b0),
    .jump        (1'b0),
    .retired     (w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        br;
    logic        zr;
    logic        jp;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] npc;
  } vec_t;

  vec_t v [12];
  int   total = 0;
  int   bad   = 0;
  int   exp_ret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    for (int c = 0; c < 20 && imem_req !== 1'b1; c++) @(negedge clk);
    check("imem_req_up", {31'h0, imem_req}, 32'h1);
  endtask

  // Fetch with gnt first and rvalid the following cycle, then retire.
  task automatic do_row(input int i);
    wait_req();
    check($sformatf("r%0d_addr", i), imem_addr, v[i].pc);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = v[i].word;
    check($sformatf("r%0d_req_low", i), {31'h0, imem_req}, 32'h0);
    check($sformatf("r%0d_iv_wait", i), {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check($sformatf("r%0d_iv", i), {31'h0, instr_valid}, 32'h1);
    check($sformatf("r%0d_instr", i), instr, v[i].word);
    check($sformatf("r%0d_op", i), {26'h0, OpCode}, {26'h0, v[i].op});
    check($sformatf("r%0d_fn", i), {26'h0, funct}, {26'h0, v[i].fn});
    check($sformatf("r%0d_pc", i), pc, v[i].pc);
    ex_done = 1'b1;
    Branch  = v[i].br;
    zero    = v[i].zr;
    jump    = v[i].jp;
    @(negedge clk);
    ex_done = 1'b0;
    Branch  = 1'b0;
    zero    = 1'b0;
    jump    = 1'b0;
    exp_ret++;
    check($sformatf("r%0d_npc", i), pc, v[i].npc);
    check($sformatf("r%0d_naddr", i), imem_addr, v[i].npc);
    check($sformatf("r%0d_retired", i), retired, exp_ret);
    check($sformatf("r%0d_iv_clr", i), {31'h0, instr_valid}, 32'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0000_3000);
    check({tag, "_pc"}, pc, 32'h0000_3000);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_iv"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_retired"}, retired, 32'h0);
  endtask

  initial begin
    //          pc            word          br    zr    jp    op     fn     next
    v[0]  = '{32'h0000_3000, 32'h3408_0005, 1'b0, 1'b0, 1'b0, 6'h0D, 6'h05, 32'h0000_3004};
    v[1]  = '{32'h0000_3004, 32'h1109_0003, 1'b1, 1'b1, 1'b0, 6'h04, 6'h03, 32'h0000_3014};
    v[2]  = '{32'h0000_3014, 32'h1109_FFFE, 1'b1, 1'b1, 1'b0, 6'h04, 6'h3E, 32'h0000_3010};
    v[3]  = '{32'h0000_3010, 32'h1109_FFFF, 1'b1, 1'b1, 1'b0, 6'h04, 6'h3F, 32'h0000_3010};
    v[4]  = '{32'h0000_3010, 32'h1109_0003, 1'b1, 1'b0, 1'b0, 6'h04, 6'h03, 32'h0000_3014};
    v[5]  = '{32'h0000_3014, 32'h0800_0C10, 1'b1, 1'b1, 1'b1, 6'h02, 6'h10, 32'h0000_3040};
    v[6]  = '{32'h0000_3040, 32'h1109_0003, 1'b0, 1'b1, 1'b0, 6'h04, 6'h03, 32'h0000_3044};
    v[7]  = '{32'h0000_3044, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 6'h02, 6'h3F, 32'h0FFF_FFFC};
    v[8]  = '{32'h0FFF_FFFC, 32'h3408_0005, 1'b0, 1'b0, 1'b0, 6'h0D, 6'h05, 32'h1000_0000};
    v[9]  = '{32'h0000_3000, 32'h3408_0005, 1'b0, 1'b0, 1'b0, 6'h0D, 6'h05, 32'h0000_3004};
    v[10] = '{32'h0000_3004, 32'h1109_0003, 1'b1, 1'b0, 1'b0, 6'h04, 6'h03, 32'h0000_3008};
    v[11] = '{32'h0000_3008, 32'h0800_0C10, 1'b1, 1'b1, 1'b1, 6'h02, 6'h10, 32'h0000_3040};

    rst_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    ex_done = 1'b0; Branch = 1'b0; zero = 1'b0; jump = 1'b0;
    w_rst_n = 1'b1; w_imem_gnt = 1'b0; w_imem_rvalid = 1'b0; w_imem_rdata = 32'h0;
    w_ex_done = 1'b0;
    #1 rst_n = 1'b0; w_rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    for (int i = 0; i <= 8; i++) do_row(i);

    // gnt withheld 5 cycles, then same-cycle gnt+rvalid, then spurious rvalid in EXEC.
    wait_req();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_req", c), {31'h0, imem_req}, 32'h1);
      check($sformatf("stall%0d_addr", c), imem_addr, 32'h1000_0000);
      @(negedge clk);
    end
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    check("same_iv", {31'h0, instr_valid}, 32'h1);
    check("same_instr", instr, 32'h0000_0020);
    check("same_fn", {26'h0, funct}, 32'h20);
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("spur_instr", instr, 32'h0000_0020);
    check("spur_iv", {31'h0, instr_valid}, 32'h1);
    ex_done = 1'b1;
    @(negedge clk);
    ex_done = 1'b0;
    exp_ret++;
    check("stall_npc", pc, 32'h1000_0004);
    check("stall_retired", retired, exp_ret);

    // Reset while in WAIT; an rvalid right after release must be dropped.
    wait_req();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_req_low", {31'h0, imem_req}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    check("late_rv_iv", {31'h0, instr_valid}, 32'h0);
    check("late_rv_instr", instr, 32'h0);
    check("restart_req", {31'h0, imem_req}, 32'h1);
    exp_ret = 0;
    for (int i = 9; i <= 11; i++) do_row(i);

    // PC wrap on a second instance reset at the top word of the address space.
    @(negedge clk);
    w_rst_n = 1'b1;
    for (int c = 0; c < 20 && w_imem_req !== 1'b1; c++) @(negedge clk);
    check("wrap_req", {31'h0, w_imem_req}, 32'h1);
    check("wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
    w_imem_gnt = 1'b1; w_imem_rvalid = 1'b1; w_imem_rdata = 32'h3408_0005;
    @(negedge clk);
    w_imem_gnt = 1'b0; w_imem_rvalid = 1'b0;
    check("wrap_iv", {31'h0, w_instr_valid}, 32'h1);
    check("wrap_op", {26'h0, w_OpCode}, 32'h0D);
    w_ex_done = 1'b1;
    @(negedge clk);
    w_ex_done = 1'b0;
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_naddr", w_imem_addr, 32'h0);
    check("wrap_retired", w_retired, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
